// File: rtl/decoder_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_seq
// Purpose  : AW-to-2^AW decoder with three operating modes:
//              direct decode of A, continuous output scan, or a single
//              START-triggered sweep across all outputs. Every output is
//              registered; the selected index dwells for DWELL enabled clocks.
// Ports    : CLK    - clock, all state changes on its rising edge
//            RESET  - synchronous active-high reset
//            G      - active-low enable (1 blanks Y and freezes sequencing)
//            MODE   - 00 direct, 01 scan, 10 single sweep, 11 as direct
//            A      - address decoded in direct mode
//            START  - one-cycle pulse that launches a sweep from IDLE
//            Y      - registered decoded outputs (polarity per ACTIVE_LOW)
//            IDX    - registered index selected in scan/sweep, else 0
//            BUSY   - high while a scan or sweep is active
//            DONE   - one-cycle pulse at sweep completion
// Revision : 1.0 - initial release
// ============================================================================
module decoder_scan_seq #(
    parameter int AW         = 2,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 G,
    input  logic [1:0]           MODE,
    input  logic [AW-1:0]        A,
    input  logic                 START,
    output logic [(1<<AW)-1:0]   Y,
    output logic [AW-1:0]        IDX,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int c_N  = 1 << AW;
    // Counter only needs to reach DWELL-1; keep at least one bit for DWELL=1.
    localparam int c_CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [c_CW-1:0] c_DWELL_LAST = c_CW'(DWELL - 1);
    localparam logic [AW-1:0]   c_IDX_LAST   = AW'(c_N - 1);
    localparam logic [c_N-1:0]  c_Y_OFF      = (ACTIVE_LOW != 0) ? {c_N{1'b1}} : {c_N{1'b0}};

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DIRECT = 2'd1;
    localparam logic [1:0] c_ST_SCAN   = 2'd2;
    localparam logic [1:0] c_ST_SWEEP  = 2'd3;

    logic [1:0]      r_state;
    logic [AW-1:0]   r_idx;
    logic [c_CW-1:0] r_cnt;
    logic [c_N-1:0]  r_y;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_state_nxt;
    logic [1:0]      w_target;
    logic            w_in_family;
    logic [AW-1:0]   w_idx_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [c_N-1:0]  w_y_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    function automatic logic [c_N-1:0] f_decode(input logic [AW-1:0] sel);
        logic [c_N-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~onehot : onehot;
    endfunction

    // Home state of the requested mode. MODE=10 homes to IDLE; SWEEP is a
    // sub-state of that mode, so it counts as "in family" as well.
    always_comb begin
        w_target = c_ST_DIRECT;
        case (MODE)
            2'b01:   w_target = c_ST_SCAN;
            2'b10:   w_target = c_ST_IDLE;
            default: w_target = c_ST_DIRECT;
        endcase
        w_in_family = (r_state == w_target) ||
                      ((w_target == c_ST_IDLE) && (r_state == c_ST_SWEEP));
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;

        if (!w_in_family) begin
            // Mode change: restart cleanly, aborting any sweep silently.
            w_state_nxt = w_target;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_SCAN, c_ST_SWEEP: begin
                    if (!G) begin
                        if (r_cnt == c_DWELL_LAST) begin
                            w_cnt_nxt = '0;
                            if ((r_state == c_ST_SWEEP) && (r_idx == c_IDX_LAST)) begin
                                w_state_nxt = c_ST_IDLE;
                                w_idx_nxt   = '0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                // Wraps N-1 -> 0 naturally in scan.
                                w_idx_nxt = r_idx + AW'(1);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + c_CW'(1);
                        end
                    end
                end
                c_ST_IDLE: begin
                    if (START && !G) begin
                        w_state_nxt = c_ST_SWEEP;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                default: ;
            endcase
        end

        // Outputs are derived from the next state so they register together.
        w_busy_nxt = (w_state_nxt == c_ST_SCAN) || (w_state_nxt == c_ST_SWEEP);
        w_y_nxt    = c_Y_OFF;
        if (!G) begin
            case (w_state_nxt)
                c_ST_DIRECT:           w_y_nxt = f_decode(A);
                c_ST_SCAN, c_ST_SWEEP: w_y_nxt = f_decode(w_idx_nxt);
                default:               w_y_nxt = c_Y_OFF;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_y     <= c_Y_OFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign Y    = r_y;
    assign IDX  = r_idx;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan_seq
// Purpose  : Directed self-checking bench for decoder_scan_seq with
//            AW=2, DWELL=4, ACTIVE_LOW=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_seq;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       G = 1'b0;
    logic [1:0] MODE = 2'b10;
    logic [1:0] A = 2'd0;
    logic       START = 1'b0;
    logic [3:0] Y;
    logic [1:0] IDX;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    decoder_scan_seq #(.AW(2), .DWELL(4), .ACTIVE_LOW(1)) dut (
        .CLK(CLK), .RESET(RESET), .G(G), .MODE(MODE), .A(A), .START(START),
        .Y(Y), .IDX(IDX), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle before sampling/driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; MODE = 2'b10; G = 1'b0; START = 1'b1;
        step();
        checks++; if (Y !== 4'b1111) begin errors++; $display("FAIL reset_y got %b expected 1111", Y); end
        checks++; if (IDX !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d expected 0", IDX); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", DONE); end
        START = 1'b0;
    endtask

    task automatic test_direct();
        logic [1:0] addr  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_y [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        RESET = 1'b0; MODE = 2'b00; G = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = addr[i];
            step();
            checks++; if (Y !== exp_y[i]) begin errors++; $display("FAIL direct_y[%0d] got %b expected %b", i, Y, exp_y[i]); end
            checks++; if (IDX !== 2'd0 || BUSY !== 1'b0) begin errors++; $display("FAIL direct_idx_busy[%0d] got %0d/%b expected 0/0", i, IDX, BUSY); end
        end
        G = 1'b1;
        step();
        checks++; if (Y !== 4'b1111) begin errors++; $display("FAIL direct_blank got %b expected 1111", Y); end
        // Reserved mode decodes like direct.
        MODE = 2'b11; G = 1'b0; A = 2'd2;
        step();
        checks++; if (Y !== 4'b1011) begin errors++; $display("FAIL reserved_y got %b expected 1011", Y); end
    endtask

    task automatic test_scan();
        int exp_idx;
        logic [3:0] exp_y;
        MODE = 2'b01; G = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_idx = (i / 4) % 4;
            exp_y   = ~(4'b0001 << exp_idx);
            checks++; if (IDX !== 2'(exp_idx)) begin errors++; $display("FAIL scan_idx[%0d] got %0d expected %0d", i, IDX, exp_idx); end
            checks++; if (Y !== exp_y) begin errors++; $display("FAIL scan_y[%0d] got %b expected %b", i, Y, exp_y); end
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL scan_busy[%0d] got %b expected 1", i, BUSY); end
        end
    endtask

    task automatic test_freeze();
        logic [1:0] exp_idx [3] = '{2'd2, 2'd2, 2'd3};
        logic [3:0] exp_y   [3] = '{4'b1011, 4'b1011, 4'b0111};
        MODE = 2'b00; G = 1'b0;
        step();
        MODE = 2'b01;
        // 10 edges: IDX=2 with one dwell cycle already consumed.
        for (int i = 0; i < 10; i++) step();
        checks++; if (IDX !== 2'd2 || Y !== 4'b1011) begin errors++; $display("FAIL freeze_pre got %0d/%b expected 2/1011", IDX, Y); end
        G = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (Y !== 4'b1111 || IDX !== 2'd2 || BUSY !== 1'b1) begin
                errors++; $display("FAIL freeze_hold[%0d] got %b/%0d/%b expected 1111/2/1", i, Y, IDX, BUSY);
            end
        end
        G = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (IDX !== exp_idx[i] || Y !== exp_y[i]) begin
                errors++; $display("FAIL freeze_resume[%0d] got %0d/%b expected %0d/%b", i, IDX, Y, exp_idx[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int exp_idx;
        logic [3:0] exp_y;
        MODE = 2'b10; G = 1'b0; START = 1'b0;
        step();
        checks++; if (Y !== 4'b1111 || BUSY !== 1'b0 || IDX !== 2'd0) begin errors++; $display("FAIL idle_outputs got %b/%b/%0d expected 1111/0/0", Y, BUSY, IDX); end
        // START with G=1 must not launch.
        G = 1'b1; START = 1'b1;
        step();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL start_gated got busy %b expected 0", BUSY); end
        G = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            START = (i == 6);  // second START mid-sweep, must be ignored
            exp_idx = i / 4;
            exp_y   = ~(4'b0001 << exp_idx);
            checks++; if (IDX !== 2'(exp_idx) || Y !== exp_y) begin errors++; $display("FAIL sweep[%0d] got %0d/%b expected %0d/%b", i, IDX, Y, exp_idx, exp_y); end
            checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin errors++; $display("FAIL sweep_flags[%0d] got busy %b done %b expected 1/0", i, BUSY, DONE); end
        end
        START = 1'b0;
        step();
        checks++; if (DONE !== 1'b1 || BUSY !== 1'b0 || Y !== 4'b1111 || IDX !== 2'd0) begin
            errors++; $display("FAIL sweep_done got done %b busy %b y %b idx %0d expected 1/0/1111/0", DONE, BUSY, Y, IDX);
        end
        step();
        checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL done_pulse got done %b busy %b expected 0/0", DONE, BUSY); end
    endtask

    task automatic test_abort();
        int done_seen;
        // Reset abort at IDX=1.
        MODE = 2'b10; G = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (IDX !== 2'd1) begin errors++; $display("FAIL abort_pre got idx %0d expected 1", IDX); end
        RESET = 1'b1;
        step();
        checks++; if (Y !== 4'b1111 || IDX !== 2'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++; $display("FAIL abort_reset got %b/%0d/%b/%b expected 1111/0/0/0", Y, IDX, BUSY, DONE);
        end
        RESET = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin step(); if (DONE === 1'b1) done_seen++; end
        checks++; if (done_seen != 0 || BUSY !== 1'b0) begin errors++; $display("FAIL abort_reset_after got done count %0d busy %b expected 0/0", done_seen, BUSY); end
        // Mode-change abort at IDX=1.
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 5; i++) step();
        MODE = 2'b00; A = 2'd2;
        step();
        checks++; if (Y !== 4'b1011 || BUSY !== 1'b0 || DONE !== 1'b0 || IDX !== 2'd0) begin
            errors++; $display("FAIL abort_mode got %b/%b/%b/%0d expected 1011/0/0/0", Y, BUSY, DONE, IDX);
        end
        step();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL abort_mode_after got done %b expected 0", DONE); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_freeze();
        test_sweep();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
